// File: rtl/ads131_pkg.sv
// Shared definitions for the ADS131A0x frame decoder: state encoding, CRC constants
// and status-word flag positions for downstream sinks.
package ads131_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STATUS  = 2'd1;
  localparam logic [1:0] ST_CHANNEL = 2'd2;
  localparam logic [1:0] ST_CRC     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    STATUS  = ST_STATUS,
    CHANNEL = ST_CHANNEL,
    CRC     = ST_CRC
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Flag positions within status_word (lower byte carries STAT_1 style flags)
  localparam int unsigned F_DRDY_LSB = 0;
  localparam int unsigned F_DRDY_MSB = 3;
  localparam int unsigned F_RESYNC   = 4;
  localparam int unsigned F_WDT      = 5;
  localparam int unsigned F_SPI      = 6;
  localparam int unsigned F_OPC      = 7;

endpackage

// File: rtl/ads131_frame_decoder_if.sv
// Byte-in / sample-out handshake bundle for the ADS131A0x frame decoder.
interface ads131_frame_decoder_if #(
  parameter int unsigned OUT_W = 32
);
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_frame_start;
  logic             in_ready;
  logic [OUT_W-1:0] sample_data;
  logic [1:0]       sample_ch;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output in_byte, in_valid, in_frame_start, sample_ready,
    input  in_ready, sample_data, sample_ch, sample_valid
  );

  modport slave (
    input  in_byte, in_valid, in_frame_start, sample_ready,
    output in_ready, sample_data, sample_ch, sample_valid
  );
endinterface

// File: rtl/ads131_crc16_byte.sv
// One-byte step of CRC-16-CCITT, MSB first; purely combinational.
module ads131_crc16_byte
  import ads131_pkg::*;
(
  input  logic [7:0]  data_byte,
  input  logic [15:0] crc_in,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[15] ^ data_byte[i]) crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      else                            crc_out = {crc_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/ads131_frame_decoder.sv
// Splits an ADS131A0x MISO frame into status and sign-extended channel samples.
// Optional trailing CRC word check is enabled with `define ADS131_FRAME_CRC_EN.
module ads131_frame_decoder
  import ads131_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WORD_BYTES = 3,
  parameter int unsigned OUT_W      = 32
) (
  input  logic                  system_clock,
  input  logic                  reset_n,
  ads131_frame_decoder_if.slave bus,
  output logic [15:0]           status_word,
  output logic                  status_valid,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic [7:0]            frame_err_count
`ifdef ADS131_FRAME_CRC_EN
  ,
  output logic                  crc_error
`endif
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned PART_W = WORD_W - 8;

  state_t             state, state_n;
  logic [1:0]         byte_idx, byte_idx_n;
  logic [1:0]         ch_idx, ch_idx_n;
  logic [PART_W-1:0]  part_q, part_n;
  logic [WORD_W-1:0]  word_next;
  logic [OUT_W-1:0]   data_q, data_n;
  logic [1:0]         sch_q, sch_n;
  logic               sv_q, sv_n;
  logic [15:0]        status_n, count_n;
  logic               status_valid_n, frame_done_n;
  logic [7:0]         err_n;
  logic               accept, word_done;

  // Only the output register can stall the byte stream
  assign bus.in_ready     = !sv_q || bus.sample_ready;
  assign bus.sample_data  = data_q;
  assign bus.sample_ch    = sch_q;
  assign bus.sample_valid = sv_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign word_next = {part_q, bus.in_byte};
  assign word_done = (byte_idx == 2'(WORD_BYTES - 1));

`ifdef ADS131_FRAME_CRC_EN
  logic [15:0] crc_q, crc_n, crc_seed, crc_next;
  logic        crc_error_n;

  assign crc_seed = bus.in_frame_start ? CRC_INIT : crc_q;

  ads131_crc16_byte u_crc (
    .data_byte (bus.in_byte),
    .crc_in    (crc_seed),
    .crc_out   (crc_next)
  );
`endif

  always_comb begin
    state_n        = state;
    byte_idx_n     = byte_idx;
    ch_idx_n       = ch_idx;
    part_n         = part_q;
    data_n         = data_q;
    sch_n          = sch_q;
    sv_n           = sv_q && !bus.sample_ready;
    status_n       = status_word;
    status_valid_n = 1'b0;
    frame_done_n   = 1'b0;
    count_n        = frame_count;
    err_n          = frame_err_count;
`ifdef ADS131_FRAME_CRC_EN
    crc_n          = crc_q;
    crc_error_n    = crc_error;
`endif
    if (accept && bus.in_frame_start) begin
      // A frame start outside IDLE aborts the frame in flight
      if (state != IDLE && frame_err_count != 8'hFF) err_n = frame_err_count + 8'd1;
      state_n    = STATUS;
      byte_idx_n = 2'd1;
      part_n     = PART_W'(bus.in_byte);
`ifdef ADS131_FRAME_CRC_EN
      crc_n      = crc_next;
`endif
    end else if (accept && state != IDLE) begin
      part_n     = word_next[PART_W-1:0];
      byte_idx_n = word_done ? 2'd0 : byte_idx + 2'd1;
`ifdef ADS131_FRAME_CRC_EN
      if (state != CRC) crc_n = crc_next;
`endif
      if (word_done) begin
        case (state)
          STATUS: begin
            status_n       = word_next[WORD_W-1 -: 16];
            status_valid_n = 1'b1;
            state_n        = CHANNEL;
            ch_idx_n       = 2'd0;
          end
          CHANNEL: begin
            data_n   = OUT_W'($signed(word_next));
            sch_n    = ch_idx;
            sv_n     = 1'b1;
            ch_idx_n = ch_idx + 2'd1;
            if (ch_idx == 2'(NUM_CH - 1)) begin
`ifdef ADS131_FRAME_CRC_EN
              state_n = CRC;
`else
              state_n      = IDLE;
              frame_done_n = 1'b1;
              count_n      = frame_count + 16'd1;
`endif
            end
          end
`ifdef ADS131_FRAME_CRC_EN
          CRC: begin
            state_n      = IDLE;
            frame_done_n = 1'b1;
            count_n      = frame_count + 16'd1;
            crc_error_n  = (crc_q != word_next[WORD_W-1 -: 16]);
          end
`endif
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      byte_idx        <= 2'd0;
      ch_idx          <= 2'd0;
      part_q          <= '0;
      data_q          <= '0;
      sch_q           <= 2'd0;
      sv_q            <= 1'b0;
      status_word     <= 16'd0;
      status_valid    <= 1'b0;
      frame_done      <= 1'b0;
      frame_count     <= 16'd0;
      frame_err_count <= 8'd0;
`ifdef ADS131_FRAME_CRC_EN
      crc_q           <= CRC_INIT;
      crc_error       <= 1'b0;
`endif
    end else begin
      state           <= state_n;
      byte_idx        <= byte_idx_n;
      ch_idx          <= ch_idx_n;
      part_q          <= part_n;
      data_q          <= data_n;
      sch_q           <= sch_n;
      sv_q            <= sv_n;
      status_word     <= status_n;
      status_valid    <= status_valid_n;
      frame_done      <= frame_done_n;
      frame_count     <= count_n;
      frame_err_count <= err_n;
`ifdef ADS131_FRAME_CRC_EN
      crc_q           <= crc_n;
      crc_error       <= crc_error_n;
`endif
    end
  end

endmodule
